// File: rtl/t16_decode_seq_if.sv
// ---------------------------------------------------------------------------
// t16_decode_seq_if
// Memory port between the t16q decode/sequencer and the memory system.
//   mem_req       sequencer -> memory  request, held until mem_ack
//   mem_is_fetch  sequencer -> memory  1 = instruction fetch at PC, 0 = data
//   mem_ack       memory -> sequencer  access done; ir_in valid on fetch ack
//   ir_in         memory -> sequencer  fetched 16-bit instruction word
// Modports: master (sequencer side), slave (memory side).
// ---------------------------------------------------------------------------
interface t16_decode_seq_if;
    logic        mem_req;
    logic        mem_is_fetch;
    logic        mem_ack;
    logic [15:0] ir_in;

    modport master (
        output mem_req,
        output mem_is_fetch,
        input  mem_ack,
        input  ir_in
    );

    modport slave (
        input  mem_req,
        input  mem_is_fetch,
        output mem_ack,
        output ir_in
    );
endinterface

// File: rtl/t16_decode_seq.sv
// ---------------------------------------------------------------------------
// t16_decode_seq
// Multi-cycle decode/sequencer for the t16q core. Owns the instruction
// register, issues the PC step as an ALU write-back to r15 on every fetch,
// and sequences a req/ack memory handshake with arbitrary latency.
//
// Ports:
//   clk            core clock, rising edge
//   rst            synchronous reset, active-high
//   mem            memory handshake (t16_decode_seq_if.master)
//   flags_i[3:0]   ALU flags packed {z, c, n, v}
//   alu_op_o[2:0]  ALU operation: 0 = ADD, 1..4 = op[3:1] of ALU group, 5 = LDUI
//   alu_rs1_o      source register 1 index
//   alu_rs2_o      source register 2 index
//   alu_imm_o      immediate operand (XLEN bits)
//   alu_use_imm_o  1 = ALU takes alu_imm_o instead of rs2
//   alu_rd_o       destination index (0 = discard)
//   alu_commit_o   register-file write strobe for alu_rd_o
//   mem_reg_o      data register index for LDR/STR
//   mem_w_en_o     1 = store
//   ir_o           current instruction register
//   illegal_o      one-cycle pulse on reserved opcode F
//
// Optional feature macro: T16Q_ILLEGAL_TRAP_EN
//   defined   : opcode F pulses illegal_o and parks the sequencer in HALT
//   undefined : opcode F is a NOP, illegal_o is tied low, HALT unreachable
// ---------------------------------------------------------------------------
module t16_decode_seq #(
    parameter int XLEN     = 16,
    parameter int PC_STEP  = 2,
    parameter int BR_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    t16_decode_seq_if.master      mem,
    input  logic [3:0]            flags_i,
    output logic [2:0]            alu_op_o,
    output logic [3:0]            alu_rs1_o,
    output logic [3:0]            alu_rs2_o,
    output logic [XLEN-1:0]       alu_imm_o,
    output logic                  alu_use_imm_o,
    output logic [3:0]            alu_rd_o,
    output logic                  alu_commit_o,
    output logic [3:0]            mem_reg_o,
    output logic                  mem_w_en_o,
    output logic [15:0]           ir_o,
    output logic                  illegal_o
);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_LDUI = 3'd5;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    // Set for the first cycle after reset so no request is raised while the
    // memory side is still recovering from an abandoned access.
    logic        boot_q;

    logic [3:0] opc, o1, o2, o3;
    assign {opc, o1, o2, o3} = ir_q;

    logic z, c, n, v;
    assign {z, c, n, v} = flags_i;

    logic cond_base, cond;
    always_comb begin
        cond_base = 1'b1;
        case (o1[3:1])
            3'd0:    cond_base = z;
            3'd1:    cond_base = c;
            3'd2:    cond_base = n;
            3'd3:    cond_base = v;
            3'd4:    cond_base = c & ~z;
            3'd5:    cond_base = (n == v);
            3'd6:    cond_base = ~z & (n == v);
            default: cond_base = 1'b1;
        endcase
    end
    assign cond = o1[0] ^ cond_base;

    logic [XLEN-1:0] imm4, imm8, br_imm;
    assign imm4   = {{(XLEN-4){1'b0}}, o3};
    assign imm8   = {{(XLEN-8){1'b0}}, o2, o3};
    assign br_imm = {{(XLEN-8){o2[3]}}, o2, o3} << BR_SHIFT;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            boot_q  <= 1'b0;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (!boot_q && mem.mem_ack) begin
                    ir_d    = mem.ir_in;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opc)
                    4'hC, 4'hD: if (mem.mem_ack) state_d = S_FETCH;
`ifdef T16Q_ILLEGAL_TRAP_EN
                    4'hF:       state_d = S_HALT;
`else
                    4'hF:       state_d = S_FETCH;
`endif
                    default:    state_d = S_FETCH;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        alu_op_o         = ALU_ADD;
        alu_rs1_o        = 4'd0;
        alu_rs2_o        = 4'd0;
        alu_imm_o        = '0;
        alu_use_imm_o    = 1'b0;
        alu_rd_o         = 4'd0;
        alu_commit_o     = 1'b0;
        mem_reg_o        = 4'd0;
        mem_w_en_o       = 1'b0;
        illegal_o        = 1'b0;
        mem.mem_req      = 1'b0;
        mem.mem_is_fetch = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    if (!boot_q) begin
                        // PC step is written back as r15 <= r15 + PC_STEP.
                        mem.mem_req      = 1'b1;
                        mem.mem_is_fetch = 1'b1;
                        alu_rs1_o        = 4'd15;
                        alu_rd_o         = 4'd15;
                        alu_imm_o        = XLEN'(PC_STEP);
                        alu_use_imm_o    = 1'b1;
                        alu_commit_o     = mem.mem_ack;
                    end
                end
                S_EXEC: begin
                    case (opc)
                        4'hA: begin
                            alu_imm_o     = imm8;
                            alu_use_imm_o = 1'b1;
                            alu_rd_o      = o1;
                            alu_commit_o  = 1'b1;
                        end
                        4'hB: begin
                            alu_op_o      = ALU_LDUI;
                            alu_rs1_o     = o1;
                            alu_rd_o      = o1;
                            alu_imm_o     = imm8;
                            alu_use_imm_o = 1'b1;
                            alu_commit_o  = 1'b1;
                        end
                        4'hC, 4'hD: begin
                            // Address computed as rs1 + imm; rd=0 so nothing
                            // is written until the data path takes over.
                            alu_rs1_o     = o2;
                            alu_imm_o     = imm4;
                            alu_use_imm_o = 1'b1;
                            mem_reg_o     = o1;
                            mem_w_en_o    = opc[0];
                            mem.mem_req   = 1'b1;
                            alu_commit_o  = mem.mem_ack;
                        end
                        4'hE: begin
                            alu_rs1_o     = 4'd15;
                            alu_imm_o     = br_imm;
                            alu_use_imm_o = 1'b1;
                            alu_rd_o      = cond ? 4'd15 : 4'd0;
                            alu_commit_o  = 1'b1;
                        end
                        4'hF: begin
`ifdef T16Q_ILLEGAL_TRAP_EN
                            illegal_o = 1'b1;
`endif
                        end
                        default: begin
                            alu_op_o      = opc[3:1];
                            alu_rs1_o     = o2;
                            alu_rs2_o     = o3;
                            alu_rd_o      = o1;
                            alu_use_imm_o = ~opc[0];
                            alu_imm_o     = imm4;
                            alu_commit_o  = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign ir_o = ir_q;

endmodule

// File: tb/tb_t16_decode_seq.sv
// ---------------------------------------------------------------------------
// tb_t16_decode_seq
// Transaction-level bench: each instruction is driven as a fetch phase with
// a chosen wait count, then an execute phase; expected ALU/memory outputs
// come from a decode model written directly from the instruction rules.
// ---------------------------------------------------------------------------
module tb_t16_decode_seq;

    localparam int PC_STEP_TB  = 2;
    localparam int BR_SHIFT_TB = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  flags_i = 4'd0;
    logic [2:0]  alu_op_o;
    logic [3:0]  alu_rs1_o, alu_rs2_o, alu_rd_o, mem_reg_o;
    logic [15:0] alu_imm_o, ir_o;
    logic        alu_use_imm_o, alu_commit_o, mem_w_en_o, illegal_o;

    t16_decode_seq_if mem_bus ();

    t16_decode_seq #(
        .XLEN(16), .PC_STEP(PC_STEP_TB), .BR_SHIFT(BR_SHIFT_TB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (mem_bus),
        .flags_i       (flags_i),
        .alu_op_o      (alu_op_o),
        .alu_rs1_o     (alu_rs1_o),
        .alu_rs2_o     (alu_rs2_o),
        .alu_imm_o     (alu_imm_o),
        .alu_use_imm_o (alu_use_imm_o),
        .alu_rd_o      (alu_rd_o),
        .alu_commit_o  (alu_commit_o),
        .mem_reg_o     (mem_reg_o),
        .mem_w_en_o    (mem_w_en_o),
        .ir_o          (ir_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rs1, rs2, rd, mi;
        logic [15:0] imm;
        logic        use_imm, commit, req, isf, wen, ill;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model_ir = 16'h0000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t nop_exp();
        exp_t e;
        e.op = 3'd0; e.rs1 = 4'd0; e.rs2 = 4'd0; e.rd = 4'd0; e.mi = 4'd0;
        e.imm = 16'd0; e.use_imm = 1'b0; e.commit = 1'b0; e.req = 1'b0;
        e.isf = 1'b0; e.wen = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t fetch_exp(input logic ack);
        exp_t e = nop_exp();
        e.rs1 = 4'd15; e.rd = 4'd15; e.imm = 16'(PC_STEP_TB); e.use_imm = 1'b1;
        e.req = 1'b1; e.isf = 1'b1; e.commit = ack;
        return e;
    endfunction

    // Decode model: instruction word + flags {z,c,n,v} + ack -> outputs.
    function automatic exp_t exec_exp(input logic [15:0] w, input logic [3:0] fl, input logic ack);
        exp_t e = nop_exp();
        int op = int'(w[15:12]);
        int o1 = int'(w[11:8]);
        int o2 = int'(w[7:4]);
        int o3 = int'(w[3:0]);
        int off;
        bit zf = fl[3], cf = fl[2], nf = fl[1], vf = fl[0];
        bit base, taken;
        if (op <= 9) begin
            e.op = 3'(op / 2); e.rs1 = 4'(o2); e.rs2 = 4'(o3); e.rd = 4'(o1);
            e.use_imm = (op % 2 == 0); e.imm = 16'(o3); e.commit = 1'b1;
        end else if (op == 10) begin
            e.imm = 16'(o2 * 16 + o3); e.rd = 4'(o1); e.use_imm = 1'b1; e.commit = 1'b1;
        end else if (op == 11) begin
            e.op = 3'd5; e.rs1 = 4'(o1); e.rd = 4'(o1); e.imm = 16'(o2 * 16 + o3);
            e.use_imm = 1'b1; e.commit = 1'b1;
        end else if (op == 12 || op == 13) begin
            e.rs1 = 4'(o2); e.imm = 16'(o3); e.use_imm = 1'b1; e.mi = 4'(o1);
            e.wen = (op == 13); e.req = 1'b1; e.commit = ack;
        end else if (op == 14) begin
            off = o2 * 16 + o3;
            if (off >= 128) off = off - 256;
            e.imm = 16'(off * (1 << BR_SHIFT_TB));
            case (o1 / 2)
                0: base = zf;
                1: base = cf;
                2: base = nf;
                3: base = vf;
                4: base = cf && !zf;
                5: base = (nf == vf);
                6: base = !zf && (nf == vf);
                default: base = 1'b1;
            endcase
            taken = base ^ (o1 % 2 == 1);
            e.rs1 = 4'd15; e.use_imm = 1'b1; e.rd = taken ? 4'd15 : 4'd0; e.commit = 1'b1;
        end else begin
`ifdef T16Q_ILLEGAL_TRAP_EN
            e.ill = 1'b1;
`endif
        end
        return e;
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        check_val({tag, ".op"},      alu_op_o,             e.op);
        check_val({tag, ".rs1"},     alu_rs1_o,            e.rs1);
        check_val({tag, ".rs2"},     alu_rs2_o,            e.rs2);
        check_val({tag, ".rd"},      alu_rd_o,             e.rd);
        check_val({tag, ".imm"},     alu_imm_o,            e.imm);
        check_val({tag, ".use_imm"}, alu_use_imm_o,        e.use_imm);
        check_val({tag, ".commit"},  alu_commit_o,         e.commit);
        check_val({tag, ".req"},     mem_bus.mem_req,      e.req);
        check_val({tag, ".mem_i"},   mem_reg_o,            e.mi);
        check_val({tag, ".w_en"},    mem_w_en_o,           e.wen);
        check_val({tag, ".illegal"}, illegal_o,            e.ill);
        if (e.req) check_val({tag, ".is_fetch"}, mem_bus.mem_is_fetch, e.isf);
        check_val({tag, ".ir"},      ir_o,                 model_ir);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_bus.mem_ack = 1'($urandom);
        mem_bus.ir_in = 16'($urandom);
        #1;
        check_val("rst.req", mem_bus.mem_req, 1'b0);
        check_val("rst.commit", alu_commit_o, 1'b0);
        tick();
        rst = 1'b0;
        model_ir = 16'h0000;
        mem_bus.mem_ack = 1'b1;   // must be ignored: no request outstanding
        #1;
        check_all("boot", nop_exp());
        tick();
        mem_bus.mem_ack = 1'b0;
    endtask

    task automatic do_fetch(input logic [15:0] w, input int fw);
        for (int k = 0; k <= fw; k++) begin
            mem_bus.mem_ack = (k == fw);
            mem_bus.ir_in = (k == fw) ? w : 16'($urandom);
            flags_i = 4'($urandom);
            #1;
            check_all("fetch", fetch_exp(k == fw));
            tick();
        end
        model_ir = w;
    endtask

    task automatic do_exec(input logic [15:0] w, input int dw, input logic [3:0] fl);
        flags_i = fl;
        if (w[15:12] == 4'hC || w[15:12] == 4'hD) begin
            for (int k = 0; k <= dw; k++) begin
                mem_bus.mem_ack = (k == dw);
                mem_bus.ir_in = 16'($urandom);
                #1;
                check_all("data", exec_exp(w, fl, k == dw));
                check_val("data.is_fetch", mem_bus.mem_is_fetch, 1'b0);
                tick();
            end
        end else begin
            mem_bus.mem_ack = 1'($urandom);   // no request: ack is ignored
            mem_bus.ir_in = 16'($urandom);
            #1;
            check_all("exec", exec_exp(w, fl, 1'b0));
            tick();
        end
        mem_bus.mem_ack = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] w, input int fw, input int dw, input logic [3:0] fl);
        $display("instr %h fetch_wait %0d data_wait %0d flags %b", w, fw, dw, fl);
        do_fetch(w, fw);
        do_exec(w, dw, fl);
    endtask

    initial begin
        logic [15:0] w;
        mem_bus.mem_ack = 1'b0;
        mem_bus.ir_in = 16'h0000;
        tick();
        do_reset();

        run_instr(16'h1123, 0, 0, 4'b0000);
        run_instr(16'h0456, 3, 0, 4'b0000);
        run_instr(16'hD345, 0, 2, 4'b0000);
        run_instr(16'hC7A1, 1, 0, 4'b0000);
        run_instr(16'hE0FE, 0, 0, 4'b1000);
        run_instr(16'hE0FE, 0, 0, 4'b0000);
        run_instr(16'hA9C3, 2, 0, 4'b0000);
        run_instr(16'hB57F, 0, 0, 4'b0000);
        run_instr(16'hEE7F, 0, 0, 4'b0000);

        // Reset in the middle of an LDR data wait.
        $display("instr c234 reset during data wait");
        do_fetch(16'hC234, 1);
        mem_bus.mem_ack = 1'b0;
        #1;
        check_all("abort.data", exec_exp(16'hC234, flags_i, 1'b0));
        tick();
        do_reset();
        run_instr(16'h3321, 0, 0, 4'b0000);

        for (int i = 0; i < 300; i++) begin
            w = 16'($urandom);
`ifdef T16Q_ILLEGAL_TRAP_EN
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
`endif
            run_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'($urandom));
        end

        // Reserved opcode.
        run_instr(16'hF000, 0, 0, 4'b0000);
`ifdef T16Q_ILLEGAL_TRAP_EN
        for (int k = 0; k < 12; k++) begin
            mem_bus.mem_ack = 1'($urandom);
            #1;
            check_all("halt", nop_exp());
            tick();
        end
        do_reset();
`endif
        run_instr(16'h2ABC, 0, 0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
